// File: rtl/uart_rx_pkt_ctl.sv
// uart_rx_pkt_ctl: frames receiver bytes as HDR, LEN, payload packets and buffers one payload.
// Define UART_PKT_CHECKSUM_EN to expect a trailing 8-bit sum byte (LEN + payload).
module uart_rx_pkt_ctl #(
  parameter logic [7:0] HDR_BYTE    = 8'hAA,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000,
  localparam int        LW          = $clog2(MAX_LEN + 1),
  localparam int        AW          = $clog2(MAX_LEN)
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          RX_Done_Sig,
  input  logic [7:0]    RX_Data,
  output logic          RX_En_Sig,
  output logic          Pkt_Valid,
  input  logic          Pkt_Ready,
  output logic [LW-1:0] Pkt_Len,
  input  logic [AW-1:0] Rd_Addr,
  output logic [7:0]    Rd_Data,
  output logic          Err_Sig,
  output logic [1:0]    Err_Code
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 2);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_PAY  = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  logic [2:0]    st_q, st_d;
  logic [TW-1:0] timer;
  logic [LW-1:0] idx;
  logic [7:0]    mem [MAX_LEN];
  logic          err_hit;
  logic [1:0]    err_val;
  logic          timed, tmo, len_bad, last;

`ifdef UART_PKT_CHECKSUM_EN
  logic [7:0]    sum;
`endif

  assign timed   = (st_q == S_LEN) || (st_q == S_PAY) || (st_q == S_CHK);
  assign tmo     = (timer == TMAX);
  assign len_bad = (RX_Data == 8'd0) || (RX_Data > 8'(MAX_LEN));
  assign last    = (idx + LW'(1)) == Pkt_Len;
  assign Rd_Data = mem[Rd_Addr];

  always_comb begin
    st_d    = st_q;
    err_hit = 1'b0;
    err_val = 2'd0;
    unique case (st_q)
      S_IDLE: begin
        if (RX_Done_Sig && RX_Data == HDR_BYTE) st_d = S_LEN;
      end
      S_LEN: begin
        if (RX_Done_Sig) begin
          if (len_bad) begin
            err_hit = 1'b1;
            err_val = 2'd1;
            st_d    = S_IDLE;
          end else begin
            st_d = S_PAY;
          end
        end else if (tmo) begin
          err_hit = 1'b1;
          err_val = 2'd2;
          st_d    = S_IDLE;
        end
      end
      S_PAY: begin
        if (RX_Done_Sig) begin
`ifdef UART_PKT_CHECKSUM_EN
          if (last) st_d = S_CHK;
`else
          if (last) st_d = S_HOLD;
`endif
        end else if (tmo) begin
          err_hit = 1'b1;
          err_val = 2'd2;
          st_d    = S_IDLE;
        end
      end
      S_CHK: begin
`ifdef UART_PKT_CHECKSUM_EN
        if (RX_Done_Sig) begin
          if (RX_Data == sum) begin
            st_d = S_HOLD;
          end else begin
            err_hit = 1'b1;
            err_val = 2'd3;
            st_d    = S_IDLE;
          end
        end else if (tmo) begin
          err_hit = 1'b1;
          err_val = 2'd2;
          st_d    = S_IDLE;
        end
`else
        st_d = S_IDLE;
`endif
      end
      S_HOLD: begin
        if (Pkt_Ready) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      st_q      <= S_IDLE;
      RX_En_Sig <= 1'b0;
      Pkt_Valid <= 1'b0;
      Pkt_Len   <= '0;
      Err_Sig   <= 1'b0;
      Err_Code  <= 2'd0;
      timer     <= '0;
      idx       <= '0;
    end else begin
      st_q      <= st_d;
      RX_En_Sig <= (st_d != S_HOLD);
      Pkt_Valid <= (st_d == S_HOLD);
      Err_Sig   <= err_hit;
      if (err_hit) Err_Code <= err_val;
      // a byte on the expiry cycle wins and restarts the gap timer
      if (timed && !RX_Done_Sig && !tmo) timer <= timer + TW'(1);
      else timer <= '0;
      if (st_q == S_LEN && RX_Done_Sig && !len_bad) begin
        Pkt_Len <= RX_Data[LW-1:0];
        idx     <= '0;
      end
      if (st_q == S_PAY && RX_Done_Sig) idx <= idx + LW'(1);
    end
  end

`ifdef UART_PKT_CHECKSUM_EN
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      sum <= 8'd0;
    end else if (RX_Done_Sig) begin
      if (st_q == S_LEN) sum <= RX_Data;
      else if (st_q == S_PAY) sum <= sum + RX_Data;
    end
  end
`endif

  // payload buffer is deliberately not reset
  always_ff @(posedge CLK) begin
    if (RSTn && st_q == S_PAY && RX_Done_Sig) mem[idx[AW-1:0]] <= RX_Data;
  end

endmodule

// File: tb/tb_uart_rx_pkt_ctl.sv
// tb_uart_rx_pkt_ctl: scoreboard bench for the packet framer.
// Expected packets/errors are queued by stimulus and popped by a monitor.
module tb_uart_rx_pkt_ctl;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 40;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int AW      = $clog2(MAX_LEN);
`ifdef UART_PKT_CHECKSUM_EN
  localparam bit CHK_EN  = 1'b1;
`else
  localparam bit CHK_EN  = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          RX_Done_Sig = 1'b0;
  logic [7:0]    RX_Data = 8'd0;
  logic          RX_En_Sig;
  logic          Pkt_Valid;
  logic          Pkt_Ready = 1'b0;
  logic [LW-1:0] Pkt_Len;
  logic [AW-1:0] Rd_Addr = '0;
  logic [7:0]    Rd_Data;
  logic          Err_Sig;
  logic [1:0]    Err_Code;

  uart_rx_pkt_ctl #(
    .HDR_BYTE(8'hAA), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .RX_Done_Sig(RX_Done_Sig), .RX_Data(RX_Data),
    .RX_En_Sig(RX_En_Sig), .Pkt_Valid(Pkt_Valid), .Pkt_Ready(Pkt_Ready),
    .Pkt_Len(Pkt_Len), .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data),
    .Err_Sig(Err_Sig), .Err_Code(Err_Code)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int exp_len[$];
  logic [7:0] exp_data[$];
  int exp_err[$];
  int pkts_expected = 0;
  int pkts_checked = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  initial begin
    bit seen = 1'b0;
    int l;
    forever begin
      @(negedge CLK);
      if (RSTn && Err_Sig) begin
        if (exp_err.size() == 0) chk("unexp_err", int'(Err_Code), 0);
        else chk("err_code", int'(Err_Code), exp_err.pop_front());
      end
      if (!Pkt_Valid) seen = 1'b0;
      else if (!seen) begin
        seen = 1'b1;
        if (exp_len.size() == 0) begin
          chk("unexp_pkt", int'(Pkt_Len), 0);
        end else begin
          l = exp_len.pop_front();
          chk("pkt_len", int'(Pkt_Len), l);
          for (int i = 0; i < l; i++) begin
            Rd_Addr = AW'(i);
            @(negedge CLK);
            chk("rd_data", int'(Rd_Data), int'(exp_data.pop_front()));
          end
          pkts_checked++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    RX_Data = b;
    RX_Done_Sig = 1'b1;
    @(posedge CLK); #1;
    RX_Done_Sig = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic release_pkt();
    int n = 0;
    while (pkts_checked < pkts_expected && n < MAX_LEN + 20) begin
      @(negedge CLK); n++;
    end
    chk("pkt_wait", pkts_checked, pkts_expected);
    @(posedge CLK); #1;
    chk("hold_en", int'(RX_En_Sig), 0);
    idle($urandom_range(0, 3));
    Pkt_Ready = 1'b1;
    @(posedge CLK); #1;
    Pkt_Ready = 1'b0;
    @(negedge CLK);
    chk("rel_valid", int'(Pkt_Valid), 0);
    chk("rel_en", int'(RX_En_Sig), 1);
    @(posedge CLK); #1;
  endtask

  // reference: a packet is accepted iff 1<=LEN<=MAX_LEN and (no checksum or sum matches)
  task automatic send_pkt(input logic [7:0] pl[$], input int delta,
                          input int max_gap, input int gap_at, input int gap_n,
                          input bit hold_junk);
    int s;
    bit good;
    s = pl.size();
    foreach (pl[i]) s += int'(pl[i]);
    s = s % 256;
    good = !CHK_EN || (delta % 256 == 0);
    if (good) begin
      exp_len.push_back(pl.size());
      foreach (pl[i]) exp_data.push_back(pl[i]);
      pkts_expected++;
    end else begin
      exp_err.push_back(3);
    end
    send_byte(8'hAA);
    idle($urandom_range(0, max_gap));
    send_byte(8'(pl.size()));
    foreach (pl[i]) begin
      if (i == gap_at) idle(gap_n);
      else idle($urandom_range(0, max_gap));
      send_byte(pl[i]);
    end
    if (CHK_EN) send_byte(8'((s + delta) % 256));
    if (good) begin
      @(negedge CLK);
      chk("valid_lat", int'(Pkt_Valid), 1);
      @(posedge CLK); #1;
      if (hold_junk) begin
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h44);
        @(negedge CLK);
        chk("junk_en", int'(RX_En_Sig), 0);
        chk("junk_valid", int'(Pkt_Valid), 1);
        @(posedge CLK); #1;
      end
      release_pkt();
    end else begin
      idle(2);
    end
  endtask

  initial begin
    logic [7:0] pl[$];
    int n;
    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1;
    @(negedge CLK);
    chk("rst_en_c1", int'(RX_En_Sig), 0);
    chk("rst_valid", int'(Pkt_Valid), 0);
    chk("rst_len", int'(Pkt_Len), 0);
    chk("rst_err", int'(Err_Sig), 0);
    chk("rst_code", int'(Err_Code), 0);
    @(negedge CLK);
    chk("rst_en_c2", int'(RX_En_Sig), 1);
    @(posedge CLK); #1;

    // basic packet, with junk bytes sent while holding
    send_byte(8'h55);
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(pl, 0, 0, -1, 0, 1'b1);
    pl = '{8'h44};
    send_pkt(pl, 0, 0, -1, 0, 1'b0);

    // length bounds
    exp_err.push_back(1);
    send_byte(8'hAA); send_byte(8'h00); idle(2);
    @(negedge CLK);
    chk("code_hold1", int'(Err_Code), 1);
    @(posedge CLK); #1;
    exp_err.push_back(1);
    send_byte(8'hAA); send_byte(8'h11); idle(2);
    pl.delete();
    for (int i = 0; i < MAX_LEN; i++) pl.push_back(8'($urandom_range(0, 255)));
    send_pkt(pl, 0, 1, -1, 0, 1'b0);

    // timeout after silence
    exp_err.push_back(2);
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h7F);
    n = 0;
    while (n < 3 * TMO) begin
      @(negedge CLK);
      if (Err_Sig) break;
      n++;
    end
    chk("tmo_cycles", n, TMO - 1);
    chk("tmo_code", int'(Err_Code), 2);
    @(posedge CLK); #1;
    // byte landing on the expiry cycle is accepted
    pl = '{8'h7F, 8'h5A};
    send_pkt(pl, 0, 0, 1, TMO - 2, 1'b0);

    if (CHK_EN) begin
      pl = '{8'h01, 8'h02};
      send_pkt(pl, 255, 0, -1, 0, 1'b0);
      pl = '{8'hFF, 8'hFF};
      send_pkt(pl, 0, 0, -1, 0, 1'b0);
    end

    // reset mid-payload
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
    RSTn = 1'b0;
    @(posedge CLK); #1;
    RSTn = 1'b1;
    @(negedge CLK);
    chk("rstmid_valid", int'(Pkt_Valid), 0);
    chk("rstmid_err", int'(Err_Sig), 0);
    @(posedge CLK); #1;
    idle(2);
    pl = '{8'hAA, 8'h10, 8'hC3};
    send_pkt(pl, 0, 0, -1, 0, 1'b0);

    // randomized mix
    for (int k = 0; k < 30; k++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        send_byte(8'($urandom_range(0, 8'hA9)));
        idle($urandom_range(0, 2));
      end else if (kind < 4) begin
        exp_err.push_back(1);
        send_byte(8'hAA);
        if ($urandom_range(0, 1) == 0) send_byte(8'h00);
        else send_byte(8'($urandom_range(MAX_LEN + 1, 255)));
        idle(2);
      end else begin
        pl.delete();
        n = $urandom_range(1, MAX_LEN);
        for (int i = 0; i < n; i++) begin
          if ($urandom_range(0, 7) == 0) pl.push_back(8'hAA);
          else pl.push_back(8'($urandom_range(0, 255)));
        end
        send_pkt(pl, (kind == 4) ? int'($urandom_range(1, 255)) : 0, 3, -1, 0, 1'b0);
      end
    end

    idle(5);
    chk("pkts_left", exp_len.size(), 0);
    chk("errs_left", exp_err.size(), 0);
    chk("pkts_seen", pkts_checked, pkts_expected);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
